// File: rtl/imem_loader.sv
// imem_loader
// Boot-time program loader sitting in front of the single-cycle CPU. A host
// streams a little-endian 16-bit word count followed by that many 32-bit
// instruction words, one byte at a time. Each completed word is written to
// instruction memory, and the CPU is released once the whole program is in place.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   load_req     host request to open a load session (honoured in IDLE/DONE/ERR)
//   byte_valid   host byte strobe
//   byte_data    host byte
//   byte_ready   loader accepts a byte this cycle
//   im_we        instruction-memory write enable, one pulse per word
//   im_addr      instruction-memory byte address (word aligned)
//   im_wdata     instruction word being written
//   cpu_start    CPU run enable (0 holds the CPU in reset)
//   busy         a load session is in progress
//   err          the last session failed (bad length or timeout)
//   words_loaded words written in the current or last session
module imem_loader #(
    parameter int unsigned IMEM_WORDS  = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_start,
    output logic        busy,
    output logic        err,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // The idle counter only has to reach TIMEOUT_CYC-1; the expiring cycle is
    // detected combinationally rather than by storing TIMEOUT_CYC itself.
    localparam int unsigned        IDLE_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = (TIMEOUT_CYC > 0) ? IDLE_W'(TIMEOUT_CYC - 1) : '0;
    localparam bit                 TIMEOUT_EN = (TIMEOUT_CYC != 0);
    localparam logic [16:0]        MAX_LEN    = 17'(IMEM_WORDS);

    state_t              r_state;
    state_t              w_nextState;
    logic [15:0]         r_len;
    logic [1:0]          r_byteIdx;
    logic [15:0]         r_wordIdx;
    logic [23:0]         r_partWord;
    logic [31:0]         r_imAddr;
    logic [31:0]         r_imWdata;
    logic [15:0]         r_wordsLoaded;
    logic [IDLE_W-1:0]   r_idleCnt;

    logic                w_ready;
    logic                w_accept;
    logic                w_timeout;
    logic [15:0]         w_lenFull;
    logic                w_lenBad;
    logic                w_lastWord;

    assign w_ready    = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA);
    assign w_accept   = byte_valid & w_ready;
    assign w_timeout  = TIMEOUT_EN && w_ready && !w_accept && (r_idleCnt == IDLE_LAST);
    assign w_lenFull  = {byte_data, r_len[7:0]};
    assign w_lenBad   = (w_lenFull == 16'd0) || ({1'b0, w_lenFull} > MAX_LEN);
    assign w_lastWord = ((r_wordIdx + 16'd1) == r_len);

    // Every output is a decode of registered state, so nothing on the host
    // side can ripple straight through to the memory or CPU.
    assign byte_ready   = w_ready;
    assign im_we        = (r_state == S_WRITE);
    assign im_addr      = r_imAddr;
    assign im_wdata     = r_imWdata;
    assign cpu_start    = (r_state == S_DONE);
    assign busy         = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                          (r_state == S_DATA) || (r_state == S_WRITE);
    assign err          = (r_state == S_ERR);
    assign words_loaded = r_wordsLoaded;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A session can only be left early through the idle
    // timeout; load_req is deliberately ignored once a session is open.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_req) w_nextState = S_LEN0;
            end
            S_LEN0: begin
                if (w_timeout)     w_nextState = S_ERR;
                else if (w_accept) w_nextState = S_LEN1;
            end
            S_LEN1: begin
                if (w_timeout)     w_nextState = S_ERR;
                else if (w_accept) w_nextState = w_lenBad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (w_timeout)                            w_nextState = S_ERR;
                else if (w_accept && r_byteIdx == 2'd3)   w_nextState = S_WRITE;
            end
            S_WRITE: begin
                w_nextState = w_lastWord ? S_DONE : S_DATA;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath: length capture, word assembly and write bookkeeping. The write
    // address and data are latched when the fourth byte arrives, so they stay
    // put outside the WRITE cycle instead of following the partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len         <= '0;
            r_byteIdx     <= '0;
            r_wordIdx     <= '0;
            r_partWord    <= '0;
            r_imAddr      <= '0;
            r_imWdata     <= '0;
            r_wordsLoaded <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_req) begin
                        r_len         <= '0;
                        r_byteIdx     <= '0;
                        r_wordIdx     <= '0;
                        r_wordsLoaded <= '0;
                    end
                end
                S_LEN0: begin
                    if (w_accept) r_len[7:0] <= byte_data;
                end
                S_LEN1: begin
                    if (w_accept) begin
                        r_len[15:8] <= byte_data;
                        r_byteIdx   <= '0;
                        r_wordIdx   <= '0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        case (r_byteIdx)
                            2'd0: r_partWord[7:0]   <= byte_data;
                            2'd1: r_partWord[15:8]  <= byte_data;
                            2'd2: r_partWord[23:16] <= byte_data;
                            2'd3: begin
                                r_imWdata <= {byte_data, r_partWord};
                                r_imAddr  <= BASE_ADDR + {14'd0, r_wordIdx, 2'b00};
                            end
                        endcase
                        r_byteIdx <= r_byteIdx + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_wordIdx     <= r_wordIdx + 16'd1;
                    r_wordsLoaded <= r_wordsLoaded + 16'd1;
                    r_byteIdx     <= '0;
                end
                default: ;
            endcase
        end
    end

    // Idle counter: runs while waiting for a byte in an open session and is
    // cleared by every accepted byte and outside the byte-accepting states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idleCnt <= '0;
        end else if (w_ready && !w_accept) begin
            r_idleCnt <= r_idleCnt + 1'b1;
        end else begin
            r_idleCnt <= '0;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader: a cycle-by-cycle vector table for the
// canonical two-word load and the length errors, randomized sessions scored
// against a program-level model, plus hand-written timeout and reset sequences.
module tb_imem_loader;

    localparam int unsigned IMEM_WORDS  = 256;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
    localparam int unsigned TIMEOUT_CYC = 16;

    localparam logic [31:0] W0 = 32'h0050_0513;
    localparam logic [31:0] W1 = 32'h00A0_0593;
    localparam logic [31:0] W2 = 32'hDDCC_BBAA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_req = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_start;
    logic        busy;
    logic        err;
    logic [15:0] words_loaded;

    int errCount   = 0;
    int checkCount = 0;
    bit lastAcc    = 1'b0;

    typedef struct {
        logic        req;
        logic        v;
        logic [7:0]  d;
        logic        ready;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        start;
        logic        busy;
        logic        err;
        logic [15:0] words;
    } vec_t;

    vec_t vecs[30];

    always #5 clk = ~clk;

    imem_loader #(
        .IMEM_WORDS (IMEM_WORDS),
        .BASE_ADDR  (BASE_ADDR),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_req    (load_req),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .im_we       (im_we),
        .im_addr     (im_addr),
        .im_wdata    (im_wdata),
        .cpu_start   (cpu_start),
        .busy        (busy),
        .err         (err),
        .words_loaded(words_loaded)
    );

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, note whether the byte is taken on this edge,
    // then move to 1 time unit after the edge where outputs are sampled.
    task automatic applyStimulus(input logic req, input logic v, input logic [7:0] d);
        load_req   = req;
        byte_valid = v;
        byte_data  = d;
        lastAcc    = v && (byte_ready === 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic checkVector(input string tag, input vec_t e);
        checkOutput({tag, ".byte_ready"},   32'(byte_ready),   32'(e.ready));
        checkOutput({tag, ".im_we"},        32'(im_we),        32'(e.we));
        checkOutput({tag, ".im_addr"},      im_addr,           e.addr);
        checkOutput({tag, ".im_wdata"},     im_wdata,          e.wdata);
        checkOutput({tag, ".cpu_start"},    32'(cpu_start),    32'(e.start));
        checkOutput({tag, ".busy"},         32'(busy),         32'(e.busy));
        checkOutput({tag, ".err"},          32'(err),          32'(e.err));
        checkOutput({tag, ".words_loaded"}, 32'(words_loaded), 32'(e.words));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".byte_ready"},   32'(byte_ready),   32'd0);
        checkOutput({tag, ".im_we"},        32'(im_we),        32'd0);
        checkOutput({tag, ".im_addr"},      im_addr,           32'd0);
        checkOutput({tag, ".im_wdata"},     im_wdata,          32'd0);
        checkOutput({tag, ".cpu_start"},    32'(cpu_start),    32'd0);
        checkOutput({tag, ".busy"},         32'(busy),         32'd0);
        checkOutput({tag, ".err"},          32'(err),          32'd0);
        checkOutput({tag, ".words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    // Random program session. The model is the program itself: a byte queue
    // the host must deliver exactly once, and the list of (address, word)
    // writes that must appear, each one cycle after its fourth byte is taken.
    task automatic runSession(input int nWords, input int maxGap, input bit randReq);
        logic [7:0]  txq[$];
        logic [31:0] expAddr[$];
        logic [31:0] expData[$];
        logic [31:0] w;
        logic [31:0] lastAddr;
        logic [7:0]  d;
        int          nAcc;
        int          writesSeen;
        int          gap;
        int          budget;
        int          cyc;
        bit          v;
        bit          expWe;
        nAcc       = 0;
        writesSeen = 0;
        cyc        = 0;
        lastAddr   = BASE_ADDR + 32'(4 * (nWords - 1));
        txq.push_back(8'(nWords));
        txq.push_back(8'(nWords >> 8));
        for (int i = 0; i < nWords; i++) begin
            w = $urandom;
            for (int b = 0; b < 4; b++) txq.push_back(w[8*b +: 8]);
            expAddr.push_back(BASE_ADDR + 32'(4 * i));
            expData.push_back(w);
        end

        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("sess.start_cpu_start", 32'(cpu_start), 32'd0);
        checkOutput("sess.start_busy",      32'(busy),      32'd1);

        gap    = $urandom_range(0, maxGap);
        budget = nWords * 4 * (maxGap + 3) + 64;
        while (writesSeen < nWords && cyc < budget) begin
            v = (gap == 0) && (txq.size() > 0);
            d = v ? txq[0] : 8'($urandom);
            applyStimulus(randReq ? 1'($urandom) : 1'b0, v, d);
            cyc++;
            expWe = 1'b0;
            if (lastAcc) begin
                void'(txq.pop_front());
                nAcc++;
                gap   = $urandom_range(0, maxGap);
                expWe = (nAcc > 2) && (((nAcc - 2) % 4) == 0);
            end else if (gap > 0) begin
                gap--;
            end
            checkOutput("sess.im_we", 32'(im_we), 32'(expWe));
            if (im_we === 1'b1) begin
                checkOutput("sess.ready_in_write", 32'(byte_ready), 32'd0);
                if (expAddr.size() == 0) begin
                    checkCount++;
                    errCount++;
                    $display("[TB] FAIL sess.extra_write: got write %0d, expected only %0d", writesSeen + 1, nWords);
                end else begin
                    checkOutput("sess.im_addr",  im_addr,  expAddr.pop_front());
                    checkOutput("sess.im_wdata", im_wdata, expData.pop_front());
                end
                writesSeen++;
            end
        end
        if (writesSeen < nWords) begin
            checkCount++;
            errCount++;
            $display("[TB] FAIL sess.budget: got %0d writes, expected %0d within %0d cycles", writesSeen, nWords, budget);
        end

        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("sess.end_cpu_start",    32'(cpu_start),    32'd1);
        checkOutput("sess.end_busy",         32'(busy),         32'd0);
        checkOutput("sess.end_err",          32'(err),          32'd0);
        checkOutput("sess.end_words_loaded", 32'(words_loaded), 32'(nWords));
        checkOutput("sess.end_bytes_left",   32'(txq.size()),   32'd0);
        checkOutput("sess.end_addr_hold",    im_addr,           lastAddr);
    endtask

    // Stall in an open session and expect the error exactly at the 16th idle cycle.
    task automatic expectTimeout(input string tag, input int expWords);
        repeat (TIMEOUT_CYC - 1) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput({tag, ".err_before"},  32'(err),  32'd0);
        checkOutput({tag, ".busy_before"}, 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput({tag, ".err"},          32'(err),          32'd1);
        checkOutput({tag, ".busy"},         32'(busy),         32'd0);
        checkOutput({tag, ".cpu_start"},    32'(cpu_start),    32'd0);
        checkOutput({tag, ".byte_ready"},   32'(byte_ready),   32'd0);
        checkOutput({tag, ".words_loaded"}, 32'(words_loaded), 32'(expWords));
    endtask

    // Watchdog so a stuck design still ends the run.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] seqBytes[$];

        // Vector table: the canonical two-word load, the length errors and a
        // one-word reload that rewrites address 0. Fields are
        // req, valid, data | ready, we, addr, wdata, start, busy, err, words.
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[5]  = '{1'b0, 1'b1, 8'h50, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 32'h0, W0,    1'b0, 1'b1, 1'b0, 16'd0};
        vecs[7]  = '{1'b0, 1'b1, 8'h93, 1'b1, 1'b0, 32'h0, W0,    1'b0, 1'b1, 1'b0, 16'd1};
        vecs[8]  = '{1'b0, 1'b1, 8'h93, 1'b1, 1'b0, 32'h0, W0,    1'b0, 1'b1, 1'b0, 16'd1};
        vecs[9]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 32'h0, W0,    1'b0, 1'b1, 1'b0, 16'd1};
        vecs[10] = '{1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 32'h0, W0,    1'b0, 1'b1, 1'b0, 16'd1};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 32'h4, W1,    1'b0, 1'b1, 1'b0, 16'd1};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h4, W1,    1'b1, 1'b0, 1'b0, 16'd2};
        vecs[13] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 32'h4, W1,    1'b1, 1'b0, 1'b0, 16'd2};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h4, W1,    1'b0, 1'b1, 1'b0, 16'd0};
        vecs[15] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h4, W1,    1'b0, 1'b1, 1'b0, 16'd0};
        vecs[16] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 32'h4, W1,    1'b0, 1'b0, 1'b1, 16'd0};
        vecs[17] = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 32'h4, W1,    1'b0, 1'b0, 1'b1, 16'd0};
        vecs[18] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h4, W1,    1'b0, 1'b1, 1'b0, 16'd0};
        vecs[19] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 32'h4, W1,    1'b0, 1'b1, 1'b0, 16'd0};
        vecs[20] = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 32'h4, W1,    1'b0, 1'b0, 1'b1, 16'd0};
        vecs[21] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 32'h4, W1,    1'b0, 1'b1, 1'b0, 16'd0};
        vecs[22] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 32'h4, W1,    1'b0, 1'b1, 1'b0, 16'd0};
        vecs[23] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h4, W1,    1'b0, 1'b1, 1'b0, 16'd0};
        vecs[24] = '{1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 32'h4, W1,    1'b0, 1'b1, 1'b0, 16'd0};
        vecs[25] = '{1'b0, 1'b1, 8'hBB, 1'b1, 1'b0, 32'h4, W1,    1'b0, 1'b1, 1'b0, 16'd0};
        vecs[26] = '{1'b0, 1'b1, 8'hCC, 1'b1, 1'b0, 32'h4, W1,    1'b0, 1'b1, 1'b0, 16'd0};
        vecs[27] = '{1'b0, 1'b1, 8'hDD, 1'b0, 1'b1, 32'h0, W2,    1'b0, 1'b1, 1'b0, 16'd0};
        vecs[28] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, W2,    1'b1, 1'b0, 1'b0, 16'd1};
        vecs[29] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, W2,    1'b1, 1'b0, 1'b0, 16'd1};

        // Power-on reset with a byte already being offered.
        #2;
        rst        = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h3C;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h3C);
        checkAllZero("idle_after_reset");

        $display("[TB] vector table");
        for (int i = 0; i < 30; i++) begin
            applyStimulus(vecs[i].req, vecs[i].v, vecs[i].d);
            checkVector($sformatf("vec%0d", i), vecs[i]);
        end

        $display("[TB] random sessions");
        for (int s = 0; s < 6; s++) begin
            runSession($urandom_range(1, 8), 5, 1'b1);
        end

        $display("[TB] full-capacity session");
        runSession(IMEM_WORDS, 1, 1'b0);

        $display("[TB] timeouts");
        applyStimulus(1'b1, 1'b0, 8'h00);
        seqBytes = '{8'h02, 8'h00, 8'hA1, 8'hB2, 8'hC3};
        foreach (seqBytes[i]) applyStimulus(1'b0, 1'b1, seqBytes[i]);
        expectTimeout("to_data", 0);

        applyStimulus(1'b1, 1'b0, 8'h00);
        seqBytes = '{8'h02, 8'h00, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
        foreach (seqBytes[i]) applyStimulus(1'b0, 1'b1, seqBytes[i]);
        checkOutput("to_word.im_we", 32'(im_we), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hE5);
        expectTimeout("to_word", 1);

        applyStimulus(1'b1, 1'b0, 8'h00);
        expectTimeout("to_len0", 0);

        $display("[TB] reset mid-session");
        applyStimulus(1'b1, 1'b0, 8'h00);
        seqBytes = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        foreach (seqBytes[i]) applyStimulus(1'b0, 1'b1, seqBytes[i]);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h55);
        checkOutput("pre_rst.words_loaded", 32'(words_loaded), 32'd1);
        checkOutput("pre_rst.im_wdata",     im_wdata,          32'h4433_2211);
        byte_valid = 1'b1;
        byte_data  = 8'h66;
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("mid_rst");
        applyStimulus(1'b0, 1'b1, 8'h66);
        checkOutput("in_rst.im_we", 32'(im_we), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'h77);
        checkOutput("in_rst.im_we", 32'(im_we), 32'd0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h77);
        checkAllZero("post_rst");
        runSession(1, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
